// File: rtl/aes_round_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_round_sequencer: iterative AES encryption round controller        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module aes_round_sequencer #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_in,
  output logic         dp_last,
  input  logic [127:0] dp_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t       state;
  logic [127:0] st;

  // The key store is indexed directly by the round counter; it is 0 in IDLE.
  assign rk_idx   = round;
  assign dp_in    = st;
  assign out_data = st;

  // Handshake flags and dp_last are registered alongside the state so that
  // they carry no combinational path from in_valid or out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      st        <= '0;
      round     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            st       <= in_data ^ rk_data;
            round    <= 4'd1;
            state    <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            dp_last  <= (NR_L == 4'd1);
          end
        end
        ROUND: begin
          st <= dp_out ^ rk_data;
          if (round == NR_L) begin
            state     <= DONE;
            dp_last   <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            round   <= round + 4'd1;
            dp_last <= ((round + 4'd1) == NR_L);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            round     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          round     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          dp_last   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_aes_round_sequencer: directed bench for NR=10 and NR=14 builds     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_aes_round_sequencer;

  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PT_X  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_in_valid, a_in_ready, a_dp_last, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_rk_data, a_dp_in, a_dp_out, a_out_data;
  logic [3:0] a_rk_idx, a_round;
  logic b_in_valid, b_in_ready, b_dp_last, b_out_valid, b_out_ready, b_busy;
  logic [127:0] b_in_data, b_rk_data, b_dp_in, b_dp_out, b_out_data;
  logic [3:0] b_rk_idx, b_round;

  logic [127:0] rk_a [16];
  logic [127:0] rk_b [16];
  int n_checks, n_fail;

  aes_round_sequencer #(.NR(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .rk_idx(a_rk_idx), .rk_data(a_rk_data), .dp_in(a_dp_in), .dp_last(a_dp_last),
    .dp_out(a_dp_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .busy(a_busy), .round(a_round));

  aes_round_sequencer #(.NR(14)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .rk_idx(b_rk_idx), .rk_data(b_rk_data), .dp_in(b_dp_in), .dp_last(b_dp_last),
    .dp_out(b_dp_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .busy(b_busy), .round(b_round));

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq = x;
    logic [7:0] inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*r+4; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o = '0;
    for (int n = 0; n < 16; n++) sb[n] = sbox(s[127-8*n -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) sr[r+4*c] = sb[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
      if (last) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] key,
                                           input int nk, input int nr);
    logic [127:0] s = pt ^ round_key(key, nk, 0);
    for (int r = 1; r <= nr; r++) s = round_fn(s, r == nr) ^ round_key(key, nk, r);
    return s;
  endfunction

  // Key store and round datapath models feeding each instance
  assign a_rk_data = rk_a[a_rk_idx];
  assign b_rk_data = rk_b[b_rk_idx];
  assign a_dp_out  = round_fn(a_dp_in, a_dp_last);
  assign b_dp_out  = round_fn(b_dp_in, b_dp_last);

  // {busy, in_ready, out_valid, dp_last, round, rk_idx}
  logic [11:0] a_stat, b_stat;
  assign a_stat = {a_busy, a_in_ready, a_out_valid, a_dp_last, a_round, a_rk_idx};
  assign b_stat = {b_busy, b_in_ready, b_out_valid, b_dp_last, b_round, b_rk_idx};

  localparam logic [11:0] ST_IDLE   = {4'b0100, 4'd0, 4'd0};
  localparam logic [11:0] ST_DONE10 = {4'b1010, 4'd10, 4'd10};
  localparam logic [11:0] ST_DONE14 = {4'b1010, 4'd14, 4'd14};

  task automatic start_a(input logic [127:0] pt);
    a_in_data  = pt;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_status_a: got %h expected %h", a_stat, ST_IDLE);
    end
    n_checks++;
    if ({a_out_data, a_dp_in} !== 256'h0) begin
      n_fail++; $display("FAIL reset_data_a: got %h expected 0", {a_out_data, a_dp_in});
    end
    n_checks++;
    if (b_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_status_b: got %h expected %h", b_stat, ST_IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips128;
    logic [11:0] exp;
    a_in_data = PT; a_in_valid = 1'b1; a_out_ready = 1'b0;
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL fips128_in_ready: got %b expected 1", a_in_ready);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      exp = {3'b100, (k == 10), 4'(k), 4'(k)};
      n_checks++;
      if (a_stat !== exp) begin
        n_fail++; $display("FAIL fips128_round%0d: got %h expected %h", k, a_stat, exp);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({a_stat, a_out_data} !== {ST_DONE10, CT128}) begin
      n_fail++; $display("FAIL fips128_out: got %h %h expected %h %h",
                         a_stat, a_out_data, ST_DONE10, CT128);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    n_checks++;
    if (a_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL fips128_back_idle: got %h expected %h", a_stat, ST_IDLE);
    end
  endtask

  task automatic test_backpressure;
    a_out_ready = 1'b0;
    start_a(PT);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_stat, a_out_data} !== {ST_DONE10, CT128}) begin
        n_fail++; $display("FAIL backpressure_hold%0d: got %h %h expected %h %h",
                           i, a_stat, a_out_data, ST_DONE10, CT128);
      end
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    n_checks++;
    if ({a_stat, a_out_data} !== {ST_DONE10, CT128}) begin
      n_fail++; $display("FAIL backpressure_release: got %h %h expected %h %h",
                         a_stat, a_out_data, ST_DONE10, CT128);
    end
    @(negedge clk);
    a_out_ready = 1'b0;
    n_checks++;
    if (a_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL backpressure_idle: got %h expected %h", a_stat, ST_IDLE);
    end
  endtask

  task automatic test_busy_input;
    logic [127:0] exp_x = aes_ref(PT_X, K128, 4, 10);
    logic [11:0]  exp;
    a_out_ready = 1'b0;
    start_a(PT_X);
    a_in_data = PT; a_in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      exp = {3'b100, (k == 10), 4'(k), 4'(k)};
      n_checks++;
      if (a_stat !== exp) begin
        n_fail++; $display("FAIL busy_round%0d: got %h expected %h", k, a_stat, exp);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({a_stat, a_out_data} !== {ST_DONE10, exp_x}) begin
      n_fail++; $display("FAIL busy_first_out: got %h %h expected %h %h",
                         a_stat, a_out_data, ST_DONE10, exp_x);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL busy_idle: got %h expected %h", a_stat, ST_IDLE);
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    n_checks++;
    if (a_stat !== {4'b1000, 4'd1, 4'd1}) begin
      n_fail++; $display("FAIL busy_second_accept: got %h expected %h", a_stat, 12'h811);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if ({a_stat, a_out_data} !== {ST_DONE10, CT128}) begin
      n_fail++; $display("FAIL busy_second_out: got %h %h expected %h %h",
                         a_stat, a_out_data, ST_DONE10, CT128);
    end
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    int in_t [4];
    int out_t [4];
    logic [127:0] out_d [4];
    int n_in = 0;
    int n_out = 0;
    logic hs_in, hs_out;
    logic [127:0] exp_x = aes_ref(PT_X, K128, 4, 10);
    a_in_data = PT; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      hs_in  = a_in_valid & a_in_ready;
      hs_out = a_out_valid & a_out_ready;
      if (hs_in) begin
        if (n_in < 4) in_t[n_in] = cyc;
        n_in++;
      end
      if (hs_out) begin
        if (n_out < 4) begin out_t[n_out] = cyc; out_d[n_out] = a_out_data; end
        n_out++;
      end
      @(negedge clk);
      if (hs_in) begin
        if (n_in == 1) a_in_data = PT_X;
        else a_in_valid = 1'b0;
      end
    end
    a_out_ready = 1'b0;
    n_checks++;
    if (n_in !== 2 || n_out !== 2) begin
      n_fail++; $display("FAIL b2b_count: got in=%0d out=%0d expected 2 2", n_in, n_out);
    end else begin
      n_checks++;
      if (in_t[1] - in_t[0] !== 12) begin
        n_fail++; $display("FAIL b2b_in_interval: got %0d expected 12", in_t[1] - in_t[0]);
      end
      n_checks++;
      if ({out_t[0] - in_t[0], out_t[1] - out_t[0]} !== {32'sd11, 32'sd12}) begin
        n_fail++; $display("FAIL b2b_out_timing: got %0d %0d expected 11 12",
                           out_t[0] - in_t[0], out_t[1] - out_t[0]);
      end
      n_checks++;
      if ({out_d[0], out_d[1]} !== {CT128, exp_x}) begin
        n_fail++; $display("FAIL b2b_data: got %h %h expected %h %h",
                           out_d[0], out_d[1], CT128, exp_x);
      end
    end
  endtask

  task automatic test_reset_mid;
    a_out_ready = 1'b0;
    start_a(PT);
    repeat (4) @(negedge clk);
    n_checks++;
    if (a_round !== 4'd5) begin
      n_fail++; $display("FAIL rstmid_round5: got %0d expected 5", a_round);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL rstmid_idle: got %h expected %h", a_stat, ST_IDLE);
    end
    rst = 1'b0;
    start_a(PT);
    repeat (10) @(negedge clk);
    n_checks++;
    if ({a_stat, a_out_data} !== {ST_DONE10, CT128}) begin
      n_fail++; $display("FAIL rstmid_fresh_out: got %h %h expected %h %h",
                         a_stat, a_out_data, ST_DONE10, CT128);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_nr14;
    logic [11:0] exp;
    b_in_data = PT; b_in_valid = 1'b1; b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      exp = {3'b100, (k == 14), 4'(k), 4'(k)};
      n_checks++;
      if (b_stat !== exp) begin
        n_fail++; $display("FAIL nr14_round%0d: got %h expected %h", k, b_stat, exp);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({b_stat, b_out_data} !== {ST_DONE14, CT256}) begin
      n_fail++; $display("FAIL nr14_out: got %h %h expected %h %h",
                         b_stat, b_out_data, ST_DONE14, CT256);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    n_checks++;
    if (b_stat !== ST_IDLE) begin
      n_fail++; $display("FAIL nr14_back_idle: got %h expected %h", b_stat, ST_IDLE);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      rk_a[r] = (r <= 10) ? round_key(K128, 4, r) : '0;
      rk_b[r] = (r <= 14) ? round_key(K256, 8, r) : '0;
    end
    test_reset;
    test_fips128;
    test_backpressure;
    test_busy_input;
    test_back_to_back;
    test_reset_mid;
    test_nr14;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Iterative AES encryption round controller. Accepts one 128-bit plaintext block over a valid/ready handshake, drives the shared combinational round datapath (SubBytes → ShiftRows → MixColumns) once per round, and performs AddRoundKey with keys fetched by round index from the key store. It emits the ciphertext over a second valid/ready handshake and sits between the block input buffer and the output stage of the cipher core.

## Interface
- NR, 10, number of rounds; legal values 10, 12 and 14 (AES-128/192/256).
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  sequencer can accept a block.
- in_data  input  128  plaintext; byte 0 = bits [127:120].
- rk_idx  output  4  round-key index requested from the key store.
- rk_data  input  128  round key for rk_idx; combinational, valid in the same cycle.
- dp_in  output  128  state presented to the round datapath.
- dp_last  output  1  final round; the datapath bypasses MixColumns.
- dp_out  input  128  round datapath result; combinational from dp_in/dp_last.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts ciphertext.
- out_data  output  128  ciphertext.
- busy  output  1  high in ROUND or DONE.
- round  output  4  current round counter.

## Operation
- State machine: IDLE, ROUND, DONE. Internal 128-bit state register `st` and 4-bit counter `round`.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid&in_ready: st <= in_data ^ rk_data (initial AddRoundKey); round <= 1; go to ROUND.
- ROUND:
  - dp_in=st; rk_idx=round; dp_last=(round==NR).
  - Each cycle: st <= dp_out ^ rk_data.
  - If round==NR, go to DONE; otherwise round <= round+1.
- DONE:
  - out_valid=1, out_data=st. Hold st and out_data stable until out_ready.
  - On out_valid&out_ready: go to IDLE and round <= 0.
- in_ready is 0 outside IDLE. in_valid in ROUND or DONE is ignored; in_data is not sampled.
- dp_in equals st in every state. dp_last is 0 outside ROUND.
- round has no wrap-around: its range is 0..NR, and it is cleared on DONE→IDLE.
- Reset values: state IDLE, st=0, round=0, in_ready=1, out_valid=0, busy=0, rk_idx=0, dp_last=0, out_data=0, dp_in=0.
- Reset takes effect in any state. It discards the block in flight with no output. out_valid is 0 in the cycle after rst is sampled high.
- out_ready while not out_valid has no effect.

## Timing
- Input handshake in cycle T: ROUND runs cycles T+1..T+NR. out_valid goes high at T+NR+1.
- With out_ready held high, the output handshake occurs at T+NR+1 and in_ready is high again at T+NR+2. The minimum block interval is NR+2 cycles: 12 for NR=10.
- Backpressure in DONE extends the stay by one cycle per low out_ready. No data is lost or altered.
- rk_idx and dp_last are registered-state decodes with no combinational path from in_valid or out_ready. in_ready and out_valid depend only on the FSM state.
- rk_data and dp_out are sampled at the clock edge in the same cycle their index or input is presented.

## Test plan
- FIPS-197 C.1 with a bench key-schedule model and datapath model. Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → out_data 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 11 cycles after the input handshake; dp_last is high only in the 10th ROUND cycle.
- Backpressure: hold out_ready low for 5 cycles in DONE → out_valid and out_data stay stable, in_ready stays 0, and the handshake completes on the first high cycle.
- Busy input: assert in_valid with a different block throughout ROUND → that block is not accepted and the first ciphertext is unchanged. The second block is accepted in the first IDLE cycle.
- Back-to-back: two FIPS-197 blocks with in_valid and out_ready held high → handshakes 12 cycles apart and both outputs correct.
- Reset mid-operation: assert rst in round 5 → next cycle is IDLE with in_ready=1, round=0 and out_valid=0. A fresh block then encrypts correctly.
- NR=14 build, FIPS-197 C.3 (key 00..1f) → out_data 8ea2b7ca516745bfeafc49904b496089, with 15-cycle latency.
